imm_decode_stage: RTL and testbench
===================================

// Module: imm_decode_stage
// PURPOSE
// - Registered, parametrised immediate-decode pipeline stage between fetch and execute.
// - Extracts and sign-extends the instruction immediate for RV32 or RV64 (XLEN) and classifies its format.
// - Precomputes the PC-relative target (pc + imm) for BRANCH/JAL/AUIPC.
// - Decouples fetch from execute with a valid/ready handshake and an optional 2-entry skid buffer.
// PARAMETERS
// - XLEN      default 32   datapath width; legal values 32 or 64.
// - PIM_EN    default 1    1: OPCODE_PIM is decoded as S-format; 0: OPCODE_PIM is flagged illegal.
// - SKID_EN   default 1    1: 2-entry skid buffer, i_ready is registered; 0: single register, i_ready = !o_valid | i_ready_out.
// PORTS
// - i_clk        in   1      clock, rising edge.
// - i_rst_n      in   1      asynchronous active-low reset.
// - i_flush      in   1      kill all held entries (pipeline redirect).
// - i_valid      in   1      upstream instruction valid.
// - o_ready      out  1      stage can accept an instruction this cycle.
// - i_instr      in   32     raw instruction word.
// - i_pc         in   XLEN   PC of i_instr.
// - o_valid      out  1      output entry valid.
// - i_ready_out  in   1      downstream accepts the output entry.
// - o_imm        out  XLEN   sign-extended / zero-filled immediate.
// - o_imm_type   out  3      imm_type_e: NONE, I, S, B, J, U, SHAMT.
// - o_target     out  XLEN   i_pc + o_imm (wraps mod 2^XLEN); 0 when type is not B/J/U-AUIPC.
// - o_pc         out  XLEN   PC passed through with the entry.
// - o_illegal    out  1      opcode not recognised; o_imm = 0, type NONE.
// BEHAVIOUR
// - Reset: o_valid=0, o_imm=0, o_imm_type=NONE, o_target=0, o_pc=0, o_illegal=0, o_ready=1; skid buffer emptied.
// - Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready_out. Latency is 1 cycle, input to o_valid.
// - Throughput is 1/cycle with i_ready_out held high. Outputs stay stable while o_valid & !i_ready_out.
// - Decode: opcode = instr[6:0]. Immediate formats:
//   - OP_IMM, LOAD, JALR: I. STORE: S. BRANCH: B. JAL: J. LUI, AUIPC: U, with {instr[31:12],12'b0} sign-extended to XLEN.
//   - OP_IMM shifts (funct3 001 or 101): type SHAMT, zero-extended.
//     - XLEN=32: shamt = instr[24:20].
//     - XLEN=64: shamt = instr[25:20].
//     - funct7[5] (SRAI) never leaks into o_imm.
//   - XLEN=64 only: OP_IMM_32 (0011011) is decoded as I or SHAMT with a 5-bit shamt. With XLEN=32 this opcode is illegal.
//   - OP, SYSTEM, MISC_MEM: type NONE, o_imm=0, not illegal.
// - Skid (SKID_EN=1): main + skid register.
//   - o_ready = skid empty, registered.
//   - An accepted input while the output is stalled goes to skid.
//   - When the output drains, skid moves to main.
//   - Never drops or duplicates an entry. Full means both entries are valid, which forces o_ready=0.
// - Flush: at the next edge, all entries are invalid, o_valid=0 and o_ready=1. An input offered in the flush cycle is discarded.
// - Simultaneous in+out with one entry held: the new entry replaces main; skid stays empty.
// - Asynchronous reset mid-transfer: all state clears immediately; no partial entry survives.
// STRUCTURE
// - Package imm_pkg holds:
//   - imm_type_e (3-bit enum).
//   - Opcode localparams (OPCODE_I/LOAD/STORE/BRANCH/JALR/JAL/AUIPC/LUI/PIM/OP_IMM_32), consistent with the shared opcode header.
//   - The FUNCT3_SL/SR constants.
//   - An entry struct {imm, type, target, pc, illegal}.
// - Sub-module imm_extract: purely combinational, parametrised by XLEN and PIM_EN. Maps instr to imm, type and illegal.
// - This module instantiates imm_extract once, adds the target adder, and holds the pipeline/skid registers and the handshake.
// TESTING
// - Reset: assert i_rst_n=0 mid-stream -> o_valid=0, o_ready=1 and all outputs 0 asynchronously.
// - Basic formats, XLEN=32:
//   - 0xFFF00093 (addi -1) -> o_imm=0xFFFFFFFF, type I.
//   - 0x123450B7 (lui) -> o_imm=0x12345000, type U.
// - Branch target: 0xFE000EE3 (beq -4) with pc=0x100 -> o_imm=0xFFFFFFFC, type B, o_target=0xFC, one cycle later.
// - XLEN=64 shifts:
//   - 0x03F09093 (slli 63) -> o_imm=63.
//   - 0x4030D093 (srai 3) -> o_imm=3, type SHAMT.
//   - 0x00100093 (addi) -> o_imm=1.
// - Backpressure: i_valid=1 every cycle with i_ready_out=0 for 3 cycles.
//   - The first 2 entries are held and o_ready falls.
//   - On release, entries emerge in order with no loss or duplication.
// - Flush and illegal:
//   - Flush with 2 entries held -> o_valid=0 next cycle.
//   - Opcode 0x7F -> o_illegal=1, o_imm=0.
//   - OPCODE_PIM with PIM_EN=0 -> illegal.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and opcode constants for the immediate-decode stage
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_J     = 3'd4,
    IMM_U     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPCODE_I         = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_PIM       = 7'b0001011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPCODE_MISC_MEM  = 7'b0001111;

  localparam logic [2:0] FUNCT3_SL = 3'b001;
  localparam logic [2:0] FUNCT3_SR = 3'b101;

  localparam int XLEN_MAX = 64;

  // Widest-case entry; narrower datapaths use the low XLEN bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_type_e           imm_type;
    logic [XLEN_MAX-1:0] target;
    logic [XLEN_MAX-1:0] pc;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction and format classification
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit PIM_EN = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == FUNCT3_SL) || (funct3 == FUNCT3_SR);

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_I: begin
        if (is_shift) begin
          // funct7 is excluded so the SRAI marker bit never reaches the immediate
          imm      = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          imm_type = IMM_SHAMT;
        end else begin
          imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
          imm_type = IMM_I;
        end
      end
      OPCODE_LOAD, OPCODE_JALR: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OPCODE_STORE: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OPCODE_PIM: begin
        if (PIM_EN) begin
          imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
          imm_type = IMM_S;
        end else begin
          illegal = 1'b1;
        end
      end
      OPCODE_BRANCH: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OPCODE_JAL: begin
        imm      = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm      = XLEN'($signed({instr[31:12], 12'b0}));
        imm_type = IMM_U;
      end
      OPCODE_OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            imm      = XLEN'(instr[24:20]);
            imm_type = IMM_SHAMT;
          end else begin
            imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
            imm_type = IMM_I;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPCODE_OP, OPCODE_SYSTEM, OPCODE_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate-decode stage with PC-relative target and skid buffer
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit PIM_EN  = 1'b1,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready_out,
  output logic [XLEN-1:0] o_imm,
  output imm_type_e       o_imm_type,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } stage_entry_t;

  logic [XLEN-1:0] ext_imm;
  imm_type_e       ext_type;
  logic            ext_illegal;
  logic            has_target;
  stage_entry_t    new_e, main_q, skid_q;
  logic            main_v, skid_v;
  logic            in_xfer, out_xfer;

  imm_extract #(.XLEN(XLEN), .PIM_EN(PIM_EN)) u_extract (
    .instr    (i_instr),
    .imm      (ext_imm),
    .imm_type (ext_type),
    .illegal  (ext_illegal)
  );

  assign has_target = (ext_type == IMM_B) || (ext_type == IMM_J) ||
                      ((ext_type == IMM_U) && (i_instr[6:0] == OPCODE_AUIPC));

  assign new_e.imm      = ext_imm;
  assign new_e.imm_type = ext_type;
  assign new_e.target   = has_target ? (i_pc + ext_imm) : '0;
  assign new_e.pc       = i_pc;
  assign new_e.illegal  = ext_illegal;

  // With the skid buffer, ready depends only on the skid flop so it is a clean register output.
  assign o_ready  = SKID_EN ? !skid_v : (!main_v || i_ready_out);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = main_v && i_ready_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (i_flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (main_v && !out_xfer) begin
      if (in_xfer) begin
        skid_q <= new_e;
        skid_v <= 1'b1;
      end
    end else if (skid_v) begin
      main_q <= skid_q;
      skid_v <= 1'b0;
    end else if (in_xfer) begin
      main_q <= new_e;
      main_v <= 1'b1;
    end else begin
      main_v <= 1'b0;
    end
  end

  assign o_valid    = main_v;
  assign o_imm      = main_q.imm;
  assign o_imm_type = main_q.imm_type;
  assign o_target   = main_q.target;
  assign o_pc       = main_q.pc;
  assign o_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for imm_decode_stage across RV32/RV64/no-skid builds
module tb_imm_decode_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready_out;
  logic [31:0] instr;
  logic [63:0] pc;
  int          vectors = 0;
  int          miscompares = 0;
  entry_t      sbq[3][$];

  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_ill;
  logic [31:0] a_imm, a_tgt, a_pc;
  logic [2:0]  a_ty;
  logic        b_valid, b_ready, b_ill;
  logic [63:0] b_imm, b_tgt, b_pc;
  logic [2:0]  b_ty;
  logic        c_valid, c_ready, c_ill;
  logic [31:0] c_imm, c_tgt, c_pc;
  logic [2:0]  c_ty;

  imm_decode_stage #(.XLEN(32), .PIM_EN(1'b1), .SKID_EN(1'b1)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(a_ready),
    .i_instr(instr), .i_pc(pc[31:0]), .o_valid(a_valid), .i_ready_out(ready_out),
    .o_imm(a_imm), .o_imm_type(a_ty), .o_target(a_tgt), .o_pc(a_pc), .o_illegal(a_ill));

  imm_decode_stage #(.XLEN(64), .PIM_EN(1'b1), .SKID_EN(1'b1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(b_ready),
    .i_instr(instr), .i_pc(pc), .o_valid(b_valid), .i_ready_out(ready_out),
    .o_imm(b_imm), .o_imm_type(b_ty), .o_target(b_tgt), .o_pc(b_pc), .o_illegal(b_ill));

  imm_decode_stage #(.XLEN(32), .PIM_EN(1'b0), .SKID_EN(1'b0)) dutnp (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(c_ready),
    .i_instr(instr), .i_pc(pc[31:0]), .o_valid(c_valid), .i_ready_out(ready_out),
    .o_imm(c_imm), .o_imm_type(c_ty), .o_target(c_tgt), .o_pc(c_pc), .o_illegal(c_ill));

  function automatic longint sx(input longint val, input int bits);
    return (val >= (longint'(1) << (bits - 1))) ? val - (longint'(1) << bits) : val;
  endfunction

  // Reference decode: immediates are assembled from their field weights in the ISA.
  function automatic entry_t model(input logic [31:0] ins, input logic [63:0] p,
                                   input int xl, input bit pim);
    entry_t      e;
    longint      v;
    logic [63:0] mask;
    bit          shift, tgt;
    e     = '0;
    v     = 0;
    tgt   = 1'b0;
    mask  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    shift = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    e.imm_type = IMM_NONE;
    case (ins[6:0])
      7'h13: if (shift) begin
               v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
               e.imm_type = IMM_SHAMT;
             end else begin
               v = sx(longint'(ins[31:20]), 12); e.imm_type = IMM_I;
             end
      7'h03, 7'h67: begin v = sx(longint'(ins[31:20]), 12); e.imm_type = IMM_I; end
      7'h23: begin v = sx(longint'({ins[31:25], ins[11:7]}), 12); e.imm_type = IMM_S; end
      7'h0B: if (pim) begin v = sx(longint'({ins[31:25], ins[11:7]}), 12); e.imm_type = IMM_S; end
             else e.illegal = 1'b1;
      7'h63: begin
               v = -4096 * longint'(ins[31]) + 2048 * longint'(ins[7])
                   + 32 * longint'(ins[30:25]) + 2 * longint'(ins[11:8]);
               e.imm_type = IMM_B; tgt = 1'b1;
             end
      7'h6F: begin
               v = -1048576 * longint'(ins[31]) + 4096 * longint'(ins[19:12])
                   + 2048 * longint'(ins[20]) + 2 * longint'(ins[30:21]);
               e.imm_type = IMM_J; tgt = 1'b1;
             end
      7'h37: begin v = 4096 * sx(longint'(ins[31:12]), 20); e.imm_type = IMM_U; end
      7'h17: begin v = 4096 * sx(longint'(ins[31:12]), 20); e.imm_type = IMM_U; tgt = 1'b1; end
      7'h1B: if (xl != 64) e.illegal = 1'b1;
             else if (shift) begin v = longint'(ins[24:20]); e.imm_type = IMM_SHAMT; end
             else begin v = sx(longint'(ins[31:20]), 12); e.imm_type = IMM_I; end
      7'h33, 7'h73, 7'h0F: ;
      default: e.illegal = 1'b1;
    endcase
    e.imm    = 64'(v) & mask;
    e.target = tgt ? ((p + 64'(v)) & mask) : 64'd0;
    e.pc     = p & mask;
    return e;
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic mon(input int id, input int xl, input bit pim, input bit skid,
                     input logic ov, input logic ordy, input logic [63:0] imm, input logic [2:0] ty,
                     input logic [63:0] tgt, input logic [63:0] p, input logic ill);
    int     held;
    bit     exp_ready;
    entry_t e;
    held      = sbq[id].size();
    exp_ready = skid ? (held < 2) : ((held == 0) || ready_out);
    chk("o_valid", id, 64'(ov), 64'(held > 0));
    chk("o_ready", id, 64'(ordy), 64'(exp_ready));
    if (ov && ready_out && held > 0) begin
      e = sbq[id].pop_front();
      chk("o_imm", id, imm, e.imm);
      chk("o_imm_type", id, 64'(ty), 64'(e.imm_type));
      chk("o_target", id, tgt, e.target);
      chk("o_pc", id, p, e.pc);
      chk("o_illegal", id, 64'(ill), 64'(e.illegal));
    end
    if (flush) sbq[id].delete();
    else if (valid && exp_ready) sbq[id].push_back(model(instr, pc, xl, pim));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, 32, 1'b1, 1'b1, a_valid, a_ready, {32'd0, a_imm}, a_ty, {32'd0, a_tgt}, {32'd0, a_pc}, a_ill);
      mon(1, 64, 1'b1, 1'b1, b_valid, b_ready, b_imm, b_ty, b_tgt, b_pc, b_ill);
      mon(2, 32, 1'b0, 1'b0, c_valid, c_ready, {32'd0, c_imm}, c_ty, {32'd0, c_tgt}, {32'd0, c_pc}, c_ill);
    end
  end

  task automatic zchk(input int id, input logic ov, input logic ordy, input logic [63:0] imm,
                      input logic [2:0] ty, input logic [63:0] tgt, input logic [63:0] p, input logic ill);
    chk("rst_valid", id, 64'(ov), 64'd0);
    chk("rst_ready", id, 64'(ordy), 64'd1);
    chk("rst_imm", id, imm, 64'd0);
    chk("rst_type", id, 64'(ty), 64'(IMM_NONE));
    chk("rst_target", id, tgt, 64'd0);
    chk("rst_pc", id, p, 64'd0);
    chk("rst_illegal", id, 64'(ill), 64'd0);
  endtask

  task automatic zchk_all();
    zchk(0, a_valid, a_ready, {32'd0, a_imm}, a_ty, {32'd0, a_tgt}, {32'd0, a_pc}, a_ill);
    zchk(1, b_valid, b_ready, b_imm, b_ty, b_tgt, b_pc, b_ill);
    zchk(2, c_valid, c_ready, {32'd0, c_imm}, c_ty, {32'd0, c_tgt}, {32'd0, c_pc}, c_ill);
    for (int i = 0; i < 3; i++) sbq[i].delete();
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] p, input bit ro, input bit fl);
    @(posedge clk);
    #1;
    valid = v; instr = ins; pc = p; ready_out = ro; flush = fl;
  endtask

  localparam logic [6:0] OPS [14] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37,
                                      7'h17, 7'h1B, 7'h0B, 7'h33, 7'h73, 7'h0F, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 14) r[6:0] = OPS[k];
    return r;
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; valid = 1'b0; ready_out = 1'b1; instr = '0; pc = '0;
    #1 rst_n = 1'b0;
    #1 zchk_all();
    @(posedge clk);
    #3 rst_n = 1'b1;

    cyc(1, 32'hFFF00093, 64'h0,   1, 0);
    cyc(1, 32'h123450B7, 64'h4,   1, 0);
    cyc(1, 32'hFE000EE3, 64'h100, 1, 0);
    cyc(1, 32'h03F09093, 64'h8,   1, 0);
    cyc(1, 32'h4030D093, 64'hC,   1, 0);
    cyc(1, 32'h00100093, 64'h10,  1, 0);
    cyc(1, 32'h0000007F, 64'h14,  1, 0);
    cyc(1, 32'hFE00AF8B, 64'h18,  1, 0);
    cyc(1, 32'h4020D09B, 64'h1C,  1, 0);
    cyc(1, 32'h80000017, 64'hFFFF_FFFF_8000_0000, 1, 0);
    cyc(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: three offers while downstream stalls, then drain.
    cyc(1, 32'h00500113, 64'h200, 0, 0);
    cyc(1, 32'h00600193, 64'h204, 0, 0);
    cyc(1, 32'h00700213, 64'h208, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 64'h0, 1, 0);

    // Flush with both entries held, input offered in the flush cycle.
    cyc(1, 32'h00800293, 64'h300, 0, 0);
    cyc(1, 32'h00900313, 64'h304, 0, 0);
    cyc(1, 32'h00A00393, 64'h308, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 32'h0, 64'h0, 1, 0);

    random_phase(2000);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 zchk_all();
    @(posedge clk);
    #3 rst_n = 1'b1;

    random_phase(500);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 64'h0, 1, 0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) chk("drained", i, 64'(sbq[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
